// File: rtl/channel_mod_scheduler.sv
// Round-robin burst scheduler sharing one channel_modulator between NUM_REQ requesters.
// Each grant loads the requester's phase increment, then streams BURST_LEN I/Q samples.
module channel_mod_scheduler #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PHASE_W   = 12,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_inph,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_quad,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic                       i_cfg_wr,
  input  logic [$clog2(NUM_REQ)-1:0] i_cfg_idx,
  input  logic [PHASE_W-1:0]         i_cfg_phase_inc,
  input  logic                       i_cfg_enable,
  output logic [WIDTH-1:0]           o_inph,
  output logic [WIDTH-1:0]           o_quad,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [PHASE_W-1:0]         o_phase_inc,
  output logic                       o_phase_inc_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_grant,
  output logic                       o_busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

  state_e             state_q;
  logic [IdxW-1:0]    grant_q;
  logic [IdxW-1:0]    last_grant_q;
  logic [CntW-1:0]    cnt_q;
  logic [PHASE_W-1:0] phase_inc_q;
  logic               phase_inc_valid_q;

  logic [PHASE_W-1:0] inc_q [NUM_REQ];
  logic [NUM_REQ-1:0] en_q;

  logic [NUM_REQ-1:0] eligible;
  logic [IdxW-1:0]    cand;
  logic [IdxW-1:0]    next_grant;
  logic               found;
  logic               streaming;
  logic               handshake;
  logic               last_beat;

  assign eligible = en_q & i_req_valid;

  // Search starts one past the previous winner so every requester gets its turn.
  always_comb begin
    found      = 1'b0;
    next_grant = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found      = 1'b1;
        next_grant = cand;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      en_q <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        inc_q[i] <= '0;
      end
    end else if (i_cfg_wr && (32'(i_cfg_idx) < NUM_REQ)) begin
      inc_q[i_cfg_idx] <= i_cfg_phase_inc;
      en_q[i_cfg_idx]  <= i_cfg_enable;
    end
  end

  assign streaming = (state_q == StStream);
  assign handshake = o_valid & i_ready;
  assign last_beat = (cnt_q == CntW'(BURST_LEN - 1));

  // The increment is captured on entry to LOAD, so later table writes only affect the next grant.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q           <= StIdle;
      grant_q           <= '0;
      last_grant_q      <= IdxW'(NUM_REQ - 1);
      cnt_q             <= '0;
      phase_inc_q       <= '0;
      phase_inc_valid_q <= 1'b0;
    end else begin
      phase_inc_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (found) begin
            grant_q           <= next_grant;
            last_grant_q      <= next_grant;
            phase_inc_q       <= inc_q[next_grant];
            phase_inc_valid_q <= 1'b1;
            state_q           <= StLoad;
          end
        end
        StLoad: begin
          cnt_q   <= '0;
          state_q <= StStream;
        end
        StStream: begin
          if (handshake) begin
            if (last_beat) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (streaming) begin
      o_req_ready[grant_q] = i_ready;
    end
  end

  assign o_valid           = streaming & i_req_valid[grant_q];
  assign o_inph            = streaming ? i_req_inph[grant_q*WIDTH +: WIDTH] : '0;
  assign o_quad            = streaming ? i_req_quad[grant_q*WIDTH +: WIDTH] : '0;
  assign o_phase_inc       = phase_inc_q;
  assign o_phase_inc_valid = phase_inc_valid_q;
  assign o_grant           = grant_q;
  assign o_busy            = (state_q != StIdle);

endmodule

// File: tb/tb_channel_mod_scheduler.sv
// Bench for channel_mod_scheduler: per-cycle reference model, grant-order vector table,
// directed burst/stall/reconfig/reset sequences and a randomized soak.
module tb_channel_mod_scheduler;

  localparam int WIDTH     = 16;
  localparam int NUM_REQ   = 4;
  localparam int PHASE_W   = 12;
  localparam int BURST_LEN = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ*WIDTH-1:0] req_inph;
  logic [NUM_REQ*WIDTH-1:0] req_quad;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     cfg_wr;
  logic [1:0]               cfg_idx;
  logic [PHASE_W-1:0]       cfg_inc;
  logic                     cfg_en;
  logic [WIDTH-1:0]         o_inph;
  logic [WIDTH-1:0]         o_quad;
  logic                     o_valid;
  logic                     rdy;
  logic [PHASE_W-1:0]       pinc;
  logic                     piv;
  logic [1:0]               grant;
  logic                     busy;

  always #5 clk = ~clk;

  channel_mod_scheduler #(
    .WIDTH    (WIDTH),
    .NUM_REQ  (NUM_REQ),
    .PHASE_W  (PHASE_W),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_req_inph       (req_inph),
    .i_req_quad       (req_quad),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_cfg_wr         (cfg_wr),
    .i_cfg_idx        (cfg_idx),
    .i_cfg_phase_inc  (cfg_inc),
    .i_cfg_enable     (cfg_en),
    .o_inph           (o_inph),
    .o_quad           (o_quad),
    .o_valid          (o_valid),
    .i_ready          (rdy),
    .o_phase_inc      (pinc),
    .o_phase_inc_valid(piv),
    .o_grant          (grant),
    .o_busy           (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: burst described by samples still owed and a pending load cycle.
  bit                 m_known = 1'b0;
  int                 m_last;
  int                 m_grant;
  logic [PHASE_W-1:0] m_inc;
  bit                 m_loading;
  int                 m_left;
  logic [PHASE_W-1:0] tbl_inc [NUM_REQ];
  bit                 tbl_en  [NUM_REQ];

  logic               s_valid, s_hs, s_piv, s_busy;
  logic [PHASE_W-1:0] s_pinc;
  logic [1:0]         s_grant;
  logic [WIDTH-1:0]   s_inph, s_quad;

  typedef struct {
    logic [3:0]         en;
    logic [3:0]         vld;
    int                 g1;
    logic [PHASE_W-1:0] inc1;
    int                 g2;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [31:0]        act_c, exp_c;
    logic [NUM_REQ-1:0] exp_rdy;
    bit                 exp_stream, exp_valid, found;
    @(negedge clk);
    s_valid = o_valid;
    s_hs    = o_valid && rdy;
    s_piv   = piv;
    s_pinc  = pinc;
    s_grant = grant;
    s_busy  = busy;
    s_inph  = o_inph;
    s_quad  = o_quad;
    if (m_known) begin
      exp_stream = (m_left > 0);
      exp_valid  = exp_stream && req_valid[m_grant];
      exp_rdy    = '0;
      if (exp_stream && rdy) exp_rdy[m_grant] = 1'b1;
      act_c = {11'd0, o_valid, req_ready, busy, piv, grant, pinc};
      exp_c = {11'd0, exp_valid, exp_rdy, (m_loading || exp_stream), m_loading, 2'(m_grant),
               m_inc};
      chk("ctrl", act_c, exp_c);
      if (exp_stream) begin
        chk("data", {o_inph, o_quad},
            {req_inph[m_grant*WIDTH +: WIDTH], req_quad[m_grant*WIDTH +: WIDTH]});
      end
    end
    // Advance the model to the state after the coming edge.
    if (rst) begin
      m_known   = 1'b1;
      m_last    = NUM_REQ - 1;
      m_grant   = 0;
      m_inc     = '0;
      m_loading = 1'b0;
      m_left    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        tbl_inc[i] = '0;
        tbl_en[i]  = 1'b0;
      end
    end else if (m_known) begin
      if (m_loading) begin
        m_loading = 1'b0;
        m_left    = BURST_LEN;
      end else if (m_left > 0) begin
        if (req_valid[m_grant] && rdy) m_left--;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          int r;
          r = (m_last + k) % NUM_REQ;
          if (!found && tbl_en[r] && req_valid[r]) begin
            found     = 1'b1;
            m_grant   = r;
            m_last    = r;
            m_loading = 1'b1;
            m_inc     = tbl_inc[r];
          end
        end
      end
      if (cfg_wr && int'(cfg_idx) < NUM_REQ) begin
        tbl_inc[cfg_idx] = cfg_inc;
        tbl_en[cfg_idx]  = cfg_en;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input logic [PHASE_W-1:0] inc, input logic en);
    cfg_wr  = 1'b1;
    cfg_idx = 2'(idx);
    cfg_inc = inc;
    cfg_en  = en;
    step();
    cfg_wr  = 1'b0;
  endtask

  // Steps until a load strobe is observed; hs counts handshakes seen before it.
  task automatic run_until_strobe(input int max, output int cyc, output int hs, output bit ok);
    cyc = 0;
    hs  = 0;
    ok  = 1'b0;
    while (cyc < max && !ok) begin
      step();
      cyc++;
      if (s_piv) ok = 1'b1;
      else if (s_hs) hs++;
    end
  endtask

  initial begin
    int cyc, hs, cnt, seq, strobes, g0_count, g1_count, rand_hs;
    bit ok, written;
    int order [5];

    vecs[0] = '{4'b1111, 4'b1111, 0, 12'h100, 1};
    vecs[1] = '{4'b0100, 4'b1111, 2, 12'h122, 2};
    vecs[2] = '{4'b1010, 4'b1110, 1, 12'h111, 3};
    vecs[3] = '{4'b1111, 4'b1001, 0, 12'h100, 3};
    vecs[4] = '{4'b1001, 4'b1001, 0, 12'h100, 3};
    vecs[5] = '{4'b1000, 4'b1000, 3, 12'h133, 3};
    vecs[6] = '{4'b0110, 4'b0011, 1, 12'h111, 1};
    order   = '{0, 1, 2, 3, 0};

    rst       = 1'b1;
    req_inph  = {4{16'hDEAD}};
    req_quad  = {4{16'hBEEF}};
    req_valid = '0;
    cfg_wr    = 1'b0;
    cfg_idx   = '0;
    cfg_inc   = '0;
    cfg_en    = 1'b0;
    rdy       = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("reset_outputs", {s_valid, s_busy, s_piv, s_pinc, s_grant}, 0);

    // No config written: nothing may ever be granted.
    req_valid = '1;
    rdy       = 1'b1;
    cnt       = 0;
    repeat (200) begin
      step();
      if (s_valid || s_piv || s_busy) cnt++;
    end
    chk("t1_no_activity", cnt, 0);

    // Single requester 2 bursting back to back.
    do_reset();
    req_valid = '1;
    rdy       = 1'b1;
    cfg_write(2, 12'h005, 1'b1);
    run_until_strobe(40, cyc, hs, ok);
    chk("t2_first_load", ok, 1);
    chk("t2_first_inc", s_pinc, 12'h005);
    chk("t2_first_grant", s_grant, 2);
    for (int b = 0; b < 3; b++) begin
      run_until_strobe(60, cyc, hs, ok);
      chk("t2_load_seen", ok, 1);
      chk("t2_burst_hs", hs, BURST_LEN);
      chk("t2_period", cyc, BURST_LEN + 2);
      chk("t2_inc", s_pinc, 12'h005);
      chk("t2_grant", s_grant, 2);
    end

    // Four requesters rotate fairly.
    do_reset();
    req_valid = '0;
    for (int r = 0; r < NUM_REQ; r++) cfg_write(r, 12'(r + 1), 1'b1);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      run_until_strobe(60, cyc, hs, ok);
      chk("t3_load_seen", ok, 1);
      chk("t3_grant", s_grant, order[k]);
      chk("t3_inc", s_pinc, 12'(order[k] + 1));
      if (k > 0) chk("t3_burst_hs", hs, BURST_LEN);
    end

    // Grant-order vector table.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      req_valid = '0;
      for (int r = 0; r < NUM_REQ; r++) cfg_write(r, 12'(32'h100 + r * 32'h11), vecs[v].en[r]);
      req_valid = vecs[v].vld;
      rdy       = 1'b1;
      run_until_strobe(40, cyc, hs, ok);
      chk("vec_load1", ok, 1);
      chk("vec_grant1", s_grant, vecs[v].g1);
      chk("vec_inc1", s_pinc, vecs[v].inc1);
      run_until_strobe(60, cyc, hs, ok);
      chk("vec_load2", ok, 1);
      chk("vec_grant2", s_grant, vecs[v].g2);
      chk("vec_burst_hs", hs, BURST_LEN);
    end

    // Requester 1 with both sides stalling; samples must come out in order, exactly 16.
    do_reset();
    req_valid = '0;
    rdy       = 1'b1;
    cfg_write(1, 12'h0AB, 1'b1);
    seq     = 0;
    strobes = 0;
    hs      = 0;
    for (int c = 0; c < 400 && strobes < 2; c++) begin
      req_valid          = {2'b00, (c % 3 != 2), 1'b0};
      rdy                = (c % 2 == 1);
      req_inph[16 +: 16] = 16'(32'h1000 + seq);
      req_quad[16 +: 16] = 16'(32'h2000 + seq);
      step();
      if (s_piv) strobes++;
      else if (s_hs && strobes == 1) begin
        chk("t4_inph", s_inph, 16'(32'h1000 + seq));
        chk("t4_quad", s_quad, 16'(32'h2000 + seq));
        seq++;
        hs++;
      end
    end
    chk("t4_two_loads", strobes, 2);
    chk("t4_burst_hs", hs, BURST_LEN);

    // Reconfigure and disable the active requester mid-burst.
    do_reset();
    req_valid = '0;
    rdy       = 1'b1;
    cfg_write(0, 12'h123, 1'b1);
    cfg_write(1, 12'h222, 1'b1);
    req_valid = 4'b0011;
    run_until_strobe(40, cyc, hs, ok);
    chk("t5_grant0", s_grant, 0);
    chk("t5_inc0", s_pinc, 12'h123);
    hs      = 0;
    written = 1'b0;
    for (int c = 0; c < 100 && hs < BURST_LEN; c++) begin
      if (hs == 5 && !written) begin
        cfg_wr  = 1'b1;
        cfg_idx = 2'd0;
        cfg_inc = 12'h7FF;
        cfg_en  = 1'b0;
        written = 1'b1;
      end else begin
        cfg_wr = 1'b0;
      end
      step();
      if (s_hs) hs++;
    end
    cfg_wr = 1'b0;
    chk("t5_burst_hs", hs, BURST_LEN);
    chk("t5_inc_kept", s_pinc, 12'h123);
    g0_count = 0;
    g1_count = 0;
    for (int b = 0; b < 3; b++) begin
      run_until_strobe(60, cyc, hs, ok);
      if (ok && s_grant == 0) g0_count++;
      if (ok && s_grant == 1) g1_count++;
    end
    chk("t5_no_regrant0", g0_count, 0);
    chk("t5_grant1_count", g1_count, 3);

    // Reset in the middle of a burst.
    do_reset();
    req_valid = '0;
    rdy       = 1'b1;
    cfg_write(0, 12'h0AA, 1'b1);
    req_valid = 4'b0001;
    run_until_strobe(40, cyc, hs, ok);
    chk("t6_load", ok, 1);
    hs = 0;
    for (int c = 0; c < 50 && hs < 8; c++) begin
      step();
      if (s_hs) hs++;
    end
    chk("t6_reached8", hs, 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t6_after_reset_valid", s_valid, 0);
    chk("t6_after_reset_busy", s_busy, 0);
    cfg_write(0, 12'h0AA, 1'b1);
    run_until_strobe(40, cyc, hs, ok);
    chk("t6_regrant", s_grant, 0);
    run_until_strobe(60, cyc, hs, ok);
    chk("t6_full_burst", hs, BURST_LEN);

    // Randomized soak against the model.
    do_reset();
    rand_hs = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NUM_REQ; r++) req_valid[r] = ($urandom_range(3) != 0);
      rdy      = ($urandom_range(3) != 0);
      cfg_wr   = ($urandom_range(7) == 0);
      cfg_idx  = 2'($urandom_range(3));
      cfg_inc  = 12'($urandom);
      cfg_en   = ($urandom_range(3) != 0);
      req_inph = {$urandom, $urandom};
      req_quad = {$urandom, $urandom};
      rst      = ($urandom_range(399) == 0);
      step();
      if (s_hs) rand_hs++;
    end
    rst    = 1'b0;
    cfg_wr = 1'b0;
    chk("rand_activity", (rand_hs > 200), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/channel_mod_scheduler.md
Name: channel_mod_scheduler

Overview:
Round-robin burst scheduler that shares one channel_modulator between NUM_REQ sample requesters. Each requester has its own phase increment, held in a local config table. For each burst the scheduler grants one requester, loads that requester's increment into the modulator, then passes exactly BURST_LEN I/Q samples through with valid/ready flow control. It sits directly upstream of channel_modulator and drives its sample and phase-increment inputs.

Parameters:
WIDTH, 16, I/Q sample width in bits
NUM_REQ, 4, number of requesters (2..16)
PHASE_W, 12, phase increment width; matches channel_modulator
BURST_LEN, 16, samples per granted burst (2..1024)

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_req_inph  in  NUM_REQ*WIDTH  requester I samples; requester r at bits [r*WIDTH +: WIDTH]
i_req_quad  in  NUM_REQ*WIDTH  requester Q samples; same packing
i_req_valid  in  NUM_REQ  per-requester sample valid
o_req_ready  out  NUM_REQ  per-requester ready
i_cfg_wr  in  1  config write strobe
i_cfg_idx  in  $clog2(NUM_REQ)  config target requester
i_cfg_phase_inc  in  PHASE_W  phase increment to store
i_cfg_enable  in  1  enable bit to store with the increment
o_inph  out  WIDTH  I sample to modulator
o_quad  out  WIDTH  Q sample to modulator
o_valid  out  1  sample valid to modulator
i_ready  in  1  modulator ready
o_phase_inc  out  PHASE_W  increment to modulator
o_phase_inc_valid  out  1  one-cycle load strobe for o_phase_inc
o_grant  out  $clog2(NUM_REQ)  currently granted requester
o_busy  out  1  high in LOAD and STREAM

Behaviour:
- Reset (synchronous, i_reset=1 at posedge):
  - State returns to IDLE.
  - All outputs go to 0; o_req_ready is all zeros.
  - Config table is cleared: every increment is 0 and every enable is 0.
  - last_grant is set to NUM_REQ-1, so the first search starts at requester 0.
  - Reset asserted mid-burst abandons the burst. The in-flight sample is not counted. The first cycle after reset is IDLE.
- Config table:
  - A write with i_cfg_wr=1 updates table[i_cfg_idx] at the posedge.
  - i_cfg_idx >= NUM_REQ is ignored.
  - A write to the currently granted requester does not alter o_phase_inc mid-burst. It takes effect at that requester's next LOAD.
- Eligibility: requester r is eligible when enable[r]=1 and i_req_valid[r]=1.
- IDLE state:
  - Each cycle, search r = last_grant+1, +2, … modulo NUM_REQ for the first eligible requester.
  - If one is found: latch grant = r, set last_grant = r, go to LOAD.
  - Otherwise stay in IDLE.
  - o_valid=0 and o_req_ready=0 throughout.
- LOAD state (exactly 1 cycle):
  - Registered outputs o_phase_inc = table[grant].inc and o_phase_inc_valid = 1 for this single cycle.
  - Burst counter is cleared to 0.
  - Next state is STREAM.
  - o_valid=0.
- STREAM state, combinational pass-through from the granted requester:
  - o_inph/o_quad come from requester grant.
  - o_valid = i_req_valid[grant].
  - o_req_ready[grant] = i_ready; all other o_req_ready bits are 0.
  - A handshake (o_valid && i_ready) increments the counter.
  - The handshake with counter = BURST_LEN-1 ends the burst: next state is IDLE.
  - Stalls on either side are unlimited. There is no timeout and the burst does not terminate early.
  - Clearing the granted requester's enable mid-burst does not abort the burst; the burst completes.
- o_grant holds the latched grant in LOAD and STREAM and holds its last value in IDLE.
- o_phase_inc holds its last loaded value outside LOAD.
- Fixed inter-burst overhead: 2 cycles with o_valid=0 (one IDLE cycle, one LOAD cycle).
- Fairness: with all requesters continuously eligible, grants rotate 0,1,…,NUM_REQ-1,0,…
- No sample is dropped or duplicated. Accepted samples out equal the sum of requester handshakes.

Test Plan:
1. Reset with no config written; drive all i_req_valid=1 for 200 cycles -> o_valid never 1, o_phase_inc_valid never 1, o_busy=0.
2. Enable requester 2 only with inc=0x005; drive valid=1 and i_ready=1 continuously. Required:
   - o_phase_inc_valid pulses with o_phase_inc=0x005.
   - 16 consecutive handshakes follow, then a 2-cycle gap, then the pattern repeats.
   - o_grant is always 2.
3. Enable requesters 0..3 with incs 1..4; all continuously valid and ready -> grant order is 0,1,2,3,0; each load strobe carries inc = grant+1; each burst has exactly 16 samples.
4. Requester 1 streaming with i_ready toggling every cycle and valid dropping on every 3rd cycle -> burst still ends after exactly 16 handshakes; the I/Q sequence out matches the input sequence in order.
5. Mid-burst, write inc=0x7FF and enable=0 to the active requester 0 -> current burst completes 16 samples with the unchanged increment; requester 0 is not granted again.
6. Assert i_reset for 1 cycle at handshake 8 of a burst -> next cycle o_valid=0 and state is IDLE; after re-enabling requester 0 the next grant is 0 and the burst contains a full 16 samples.
